// File: rtl/rv32i_decode_stage_if.sv
// Fetch-to-execute bundle for the RV32I decode stage.
// The slave modport is the decode stage itself and the master modport is its environment.
interface rv32i_decode_stage_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instr;
    logic [PC_WIDTH-1:0] in_pc;

    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [3:0]          alu_op;
    logic [4:0]          rd_addr;
    logic [4:0]          rs1_addr;
    logic [4:0]          rs2_addr;
    logic [31:0]         imm;
    logic                imm_as_rs2;
    logic                pc_as_rs1;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic [2:0]          mem_funct3;
    logic                branch;
    logic [2:0]          br_cond;
    logic                jump;
    logic                jump_reg;
    logic                illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, alu_op, rd_addr, rs1_addr, rs2_addr, imm,
               imm_as_rs2, pc_as_rs1, reg_write, mem_read, mem_write, mem_funct3, branch,
               br_cond, jump, jump_reg, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, alu_op, rd_addr, rs1_addr, rs2_addr, imm,
               imm_as_rs2, pc_as_rs1, reg_write, mem_read, mem_write, mem_funct3, branch,
               br_cond, jump, jump_reg, illegal
    );
endinterface

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: decodes the incoming word and queues the decoded result in a small FIFO.
// The queue head drives execute, and every output field reads zero while the head is invalid.
module rv32i_decode_stage #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned OUT_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic                 flush,
    rv32i_decode_stage_if.slave bus
);
    localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [3:0]          alu_op;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
        logic                imm_as_rs2;
        logic                pc_as_rs1;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [2:0]          mem_funct3;
        logic                branch;
        logic [2:0]          br_cond;
        logic                jump;
        logic                jump_reg;
        logic                illegal;
    } dec_t;

    dec_t            dec;
    dec_t            mem_q [OUT_DEPTH];
    dec_t            head;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            in_ready;
    logic            out_valid;
    logic            push;
    logic            pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Combinational RV32I decode of the incoming word.
    always_comb begin
        logic [31:0] i;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ill;
        i   = bus.in_instr;
        f3  = i[14:12];
        f7  = i[31:25];
        ill = 1'b0;
        dec = '0;
        dec.pc  = bus.in_pc;
        dec.rd  = i[11:7];
        dec.rs1 = i[19:15];
        dec.rs2 = i[24:20];
        case (i[6:2])
            5'h00: begin // load
                dec.imm        = {{20{i[31]}}, i[31:20]};
                dec.imm_as_rs2 = 1'b1;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_funct3 = f3;
                ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            5'h03: ; // fence decodes to a NOP
            5'h04: begin // op-imm
                dec.imm        = {{20{i[31]}}, i[31:20]};
                dec.imm_as_rs2 = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_op     = {(f3 == 3'd5) & i[30], f3};
                if (f3 == 3'd1) ill = (f7 != 7'h00);
                if (f3 == 3'd5) ill = (f7 != 7'h00) && (f7 != 7'h20);
            end
            5'h05: begin // auipc
                dec.imm        = {i[31:12], 12'b0};
                dec.pc_as_rs1  = 1'b1;
                dec.imm_as_rs2 = 1'b1;
                dec.reg_write  = 1'b1;
            end
            5'h08: begin // store
                dec.imm        = {{20{i[31]}}, i[31:25], i[11:7]};
                dec.imm_as_rs2 = 1'b1;
                dec.mem_write  = 1'b1;
                dec.mem_funct3 = f3;
                ill = (f3 > 3'd2);
            end
            5'h0c: begin // op
                dec.alu_op    = {i[30], f3};
                dec.reg_write = 1'b1;
                ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            5'h0d: begin // lui
                dec.rs1        = 5'd0;
                dec.imm        = {i[31:12], 12'b0};
                dec.imm_as_rs2 = 1'b1;
                dec.reg_write  = 1'b1;
            end
            5'h18: begin // branch
                dec.imm     = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                dec.branch  = 1'b1;
                dec.br_cond = f3;
                case (f3[2:1])
                    2'b00:   dec.alu_op = 4'b1000;
                    2'b10:   dec.alu_op = 4'b0010;
                    2'b11:   dec.alu_op = 4'b0011;
                    default: ill = 1'b1;
                endcase
            end
            5'h19: begin // jalr
                dec.imm        = {{20{i[31]}}, i[31:20]};
                dec.jump_reg   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.imm_as_rs2 = 1'b1;
                ill = (f3 != 3'd0);
            end
            5'h1b: begin // jal
                dec.imm        = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                dec.jump       = 1'b1;
                dec.pc_as_rs1  = 1'b1;
                dec.imm_as_rs2 = 1'b1;
                dec.reg_write  = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (i[1:0] != 2'b11) ill = 1'b1;
        // Illegal entries still travel down the pipe but must not cause side effects.
        if (ill) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.jump_reg  = 1'b0;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
        dec.illegal = ill;
    end

    // No same-cycle pass-through: a full FIFO refuses input even while it pops.
    assign in_ready  = rst_n & ~flush & (count_q < CntW'(OUT_DEPTH));
    assign out_valid = rst_n & (count_q != '0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready & ~flush;

    // Pointer and occupancy bookkeeping; flush empties the queue like reset does.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; it needs no reset because count_q qualifies every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    // Head fields are forced to zero while no entry is valid.
    always_comb begin
        head = out_valid ? mem_q[rd_ptr_q] : '0;
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_pc     = head.pc;
    assign bus.alu_op     = head.alu_op;
    assign bus.rd_addr    = head.rd;
    assign bus.rs1_addr   = head.rs1;
    assign bus.rs2_addr   = head.rs2;
    assign bus.imm        = head.imm;
    assign bus.imm_as_rs2 = head.imm_as_rs2;
    assign bus.pc_as_rs1  = head.pc_as_rs1;
    assign bus.reg_write  = head.reg_write;
    assign bus.mem_read   = head.mem_read;
    assign bus.mem_write  = head.mem_write;
    assign bus.mem_funct3 = head.mem_funct3;
    assign bus.branch     = head.branch;
    assign bus.br_cond    = head.br_cond;
    assign bus.jump       = head.jump;
    assign bus.jump_reg   = head.jump_reg;
    assign bus.illegal    = head.illegal;
endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Self-checking bench for rv32i_decode_stage: directed decode vectors, backpressure,
// flush and reset scenarios, then randomized traffic against a queue-based reference model.
module tb_rv32i_decode_stage;
    localparam int unsigned PCW   = 32;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [3:0]     alu_op;
        logic [4:0]     rd;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [31:0]    imm;
        logic           imm_as_rs2;
        logic           pc_as_rs1;
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
        logic [2:0]     mem_funct3;
        logic           branch;
        logic [2:0]     br_cond;
        logic           jump;
        logic           jump_reg;
        logic           illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t mq[$];
    logic [PCW-1:0] popped[$];

    rv32i_decode_stage_if #(.PC_WIDTH(PCW)) bus ();

    rv32i_decode_stage #(.PC_WIDTH(PCW), .OUT_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference decode, written from the instruction-set rules per full 7-bit opcode.
    function automatic exp_t model(input logic [31:0] w, input logic [PCW-1:0] pc);
        exp_t        e;
        logic        legal;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [12:0] boff;
        logic [20:0] joff;
        e     = '0;
        legal = 1'b1;
        f3    = w[14:12];
        f7    = w[31:25];
        boff  = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        joff  = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        e.pc  = pc;
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        case (w[6:0])
            7'h03: begin
                e.imm = 32'($signed(w[31:20])); e.imm_as_rs2 = 1; e.mem_read = 1;
                e.reg_write = 1; e.mem_funct3 = f3;
                legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            end
            7'h0f: ;
            7'h13: begin
                e.imm = 32'($signed(w[31:20])); e.imm_as_rs2 = 1; e.reg_write = 1;
                e.alu_op = {(f3 == 3'd5) ? w[30] : 1'b0, f3};
                if (f3 == 3'd1) legal = (f7 == 7'h00);
                if (f3 == 3'd5) legal = f7 inside {7'h00, 7'h20};
            end
            7'h17: begin
                e.imm = w & 32'hFFFFF000; e.pc_as_rs1 = 1; e.imm_as_rs2 = 1; e.reg_write = 1;
            end
            7'h23: begin
                e.imm = 32'($signed({w[31:25], w[11:7]})); e.imm_as_rs2 = 1; e.mem_write = 1;
                e.mem_funct3 = f3; legal = (f3 <= 3'd2);
            end
            7'h33: begin
                e.alu_op = {w[30], f3}; e.reg_write = 1;
                legal = (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
            end
            7'h37: begin
                e.rs1 = 5'd0; e.imm = w & 32'hFFFFF000; e.imm_as_rs2 = 1; e.reg_write = 1;
            end
            7'h63: begin
                e.imm = 32'($signed(boff)); e.branch = 1; e.br_cond = f3;
                if (f3 == 3'd0 || f3 == 3'd1) e.alu_op = 4'b1000;
                else if (f3 == 3'd4 || f3 == 3'd5) e.alu_op = 4'b0010;
                else if (f3 == 3'd6 || f3 == 3'd7) e.alu_op = 4'b0011;
                else legal = 1'b0;
            end
            7'h67: begin
                e.imm = 32'($signed(w[31:20])); e.jump_reg = 1; e.reg_write = 1;
                e.imm_as_rs2 = 1; legal = (f3 == 3'd0);
            end
            7'h6f: begin
                e.imm = 32'($signed(joff)); e.jump = 1; e.pc_as_rs1 = 1; e.imm_as_rs2 = 1;
                e.reg_write = 1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.illegal = 1; e.reg_write = 0; e.mem_read = 0; e.mem_write = 0;
            e.branch = 0; e.jump = 0; e.jump_reg = 0;
        end
        if (e.rd == 5'd0) e.reg_write = 0;
        return e;
    endfunction

    // For illegal entries only pc, the illegal flag and the suppressed controls are defined.
    function automatic exp_t mask_ill(input exp_t e);
        exp_t m;
        m = '0;
        m.pc = e.pc; m.illegal = e.illegal; m.reg_write = e.reg_write;
        m.mem_read = e.mem_read; m.mem_write = e.mem_write; m.branch = e.branch;
        m.jump = e.jump; m.jump_reg = e.jump_reg;
        return m;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a = '{bus.out_pc, bus.alu_op, bus.rd_addr, bus.rs1_addr, bus.rs2_addr, bus.imm,
              bus.imm_as_rs2, bus.pc_as_rs1, bus.reg_write, bus.mem_read, bus.mem_write,
              bus.mem_funct3, bus.branch, bus.br_cond, bus.jump, bus.jump_reg, bus.illegal};
        if (mq.size() != 0 && mq[0].illegal) a = mask_ill(a);
        return a;
    endfunction

    function automatic exp_t head_exp();
        if (mq.size() == 0) return '0;
        return mq[0].illegal ? mask_ill(mq[0]) : mq[0];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: w[6:0] = 7'h03;  1: w[6:0] = 7'h0f;  2: w[6:0] = 7'h13;  3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h23;  5: w[6:0] = 7'h33;  6: w[6:0] = 7'h37;  7: w[6:0] = 7'h63;
            8: w[6:0] = 7'h67;  9: w[6:0] = 7'h6f;
            default: ;
        endcase
        if ($urandom_range(0, 2) == 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [PCW-1:0] pc,
                         input logic ordy, input logic fl);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
    endtask

    // Advance one rising edge and apply the same transfer rules to the model queue.
    task automatic tick();
        logic push, pop;
        push = bus.in_valid && rst_n && !flush && (mq.size() < DEPTH);
        pop  = rst_n && !flush && (mq.size() != 0) && bus.out_ready;
        @(posedge clk);
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            if (pop) begin
                popped.push_back(mq[0].pc);
                void'(mq.pop_front());
            end
            if (push) mq.push_back(model(bus.in_instr, bus.in_pc));
        end
    endtask

    task automatic test_reset();
        exp_t a;
        rst_n = 1'b0;
        drive(1'b1, 32'h00000013, 32'h10, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h00000013, 32'h10, 1'b1, 1'b0);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 0", bus.out_valid,
                     bus.in_ready);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        a = sample();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || a !== exp_t'('0)) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b fields=%h want 0 1 0",
                     bus.out_valid, bus.in_ready, a);
        end
        tick();
    endtask

    task automatic test_decode();
        logic [31:0] words [6];
        logic [60:0] got, want;
        exp_t        a, e;
        words = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h123452B7, 32'h00000000,
                  32'h02000033};
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, words[k], PCW'(32'h1000 + 4 * k), 1'b0, 1'b0);
            tick();
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            a = sample();
            e = head_exp();
            tests++;
            if (bus.out_valid !== 1'b1 || a !== e) begin
                fails++;
                $display("FAIL decode_%08h: valid=%b got %h want %h", words[k], bus.out_valid,
                         a, e);
            end
            got  = '0;
            want = '0;
            case (k)
                0: begin
                    got  = {bus.alu_op, bus.rd_addr, bus.rs1_addr, bus.imm, bus.imm_as_rs2,
                            bus.reg_write};
                    want = {4'h0, 5'd1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1};
                end
                1: begin
                    got  = {bus.mem_write, bus.mem_funct3, bus.rs1_addr, bus.rs2_addr, bus.imm,
                            bus.reg_write};
                    want = {1'b1, 3'd2, 5'd1, 5'd2, 32'd8, 1'b0};
                end
                2: begin
                    got  = {bus.branch, bus.br_cond, bus.alu_op, bus.imm};
                    want = {1'b1, 3'd0, 4'b1000, 32'hFFFFFFFC};
                end
                3: begin
                    got  = {bus.imm, bus.rs1_addr, bus.reg_write};
                    want = {32'h12345000, 5'd0, 1'b1};
                end
                default: begin
                    got  = {bus.illegal, bus.reg_write};
                    want = {1'b1, 1'b0};
                end
            endcase
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL known_%08h: got %h want %h", words[k], got, want);
            end
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        int          sent;
        int          budget;
        exp_t        a;
        for (int k = 0; k < 3; k++) w[k] = rand_instr();
        popped.delete();
        sent = 0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, w[sent], PCW'(32'h100 + 4 * sent), 1'b0, 1'b0);
            tests++;
            if (bus.in_ready !== (c < 2)) begin
                fails++;
                $display("FAIL bp_in_ready_%0d: got %b want %b", c, bus.in_ready, c < 2);
            end
            if (bus.in_ready === 1'b1) sent++;
            tick();
        end
        budget = 0;
        while (popped.size() < 3 && budget < 12) begin
            drive(sent < 3, w[(sent < 3) ? sent : 2], PCW'(32'h100 + 4 * sent), 1'b1, 1'b0);
            a = sample();
            tests++;
            if (a !== head_exp()) begin
                fails++;
                $display("FAIL bp_head: got %h want %h", a, head_exp());
            end
            if (sent < 3 && mq.size() < DEPTH) sent++;
            tick();
            budget++;
        end
        tests++;
        if (popped.size() != 3 || popped[0] !== 32'h100 || popped[1] !== 32'h104 ||
            popped[2] !== 32'h108) begin
            fails++;
            $display("FAIL bp_order: got %0d entries, first pcs %h %h %h want 100 104 108",
                     popped.size(), (popped.size() > 0) ? popped[0] : 32'hx,
                     (popped.size() > 1) ? popped[1] : 32'hx,
                     (popped.size() > 2) ? popped[2] : 32'hx);
        end
    endtask

    task automatic test_flush();
        exp_t a;
        popped.delete();
        drive(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00300193, 32'hDEAD0, 1'b1, 1'b1);
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL flush_cycle: in_ready=%b out_valid=%b want 0 1", bus.in_ready,
                     bus.out_valid);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            a = sample();
            tests++;
            if (bus.out_valid !== 1'b0 || a !== exp_t'('0)) begin
                fails++;
                $display("FAIL flush_empty_%0d: out_valid=%b fields=%h want 0 0", c,
                         bus.out_valid, a);
            end
            tick();
        end
        tests++;
        if (popped.size() != 0) begin
            fails++;
            $display("FAIL flush_drop: got %0d delivered entries want 0", popped.size());
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h00400213, 32'h300, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00500293, 32'h304, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00600313, 32'h308, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_cycle: out_valid=%b in_ready=%b want 0 0", bus.out_valid,
                     bus.in_ready);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_after: out_valid=%b in_ready=%b want 0 1", bus.out_valid,
                     bus.in_ready);
        end
        tick();
    endtask

    task automatic test_random();
        exp_t        a;
        logic        fl;
        logic [31:0] pc;
        pc = 32'h8000;
        for (int c = 0; c < 600; c++) begin
            fl = ($urandom_range(0, 24) == 0);
            drive($urandom_range(0, 3) != 0, rand_instr(), pc, $urandom_range(0, 2) != 0, fl);
            pc = pc + 4;
            a = sample();
            tests++;
            if (bus.out_valid !== (mq.size() != 0) ||
                bus.in_ready !== (!fl && mq.size() < DEPTH) || a !== head_exp()) begin
                fails++;
                $display("FAIL rand_%0d: valid=%b ready=%b got %h want valid=%b %h", c,
                         bus.out_valid, bus.in_ready, a, mq.size() != 0, head_exp());
            end
            tick();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
